// File: rtl/mem_stage_dmem_ctrl.sv
// rtl/mem_stage_dmem_ctrl.sv - fixed-latency data-memory responder for the MEM stage
// Optional macro DMEM_PERF_CNT_EN adds saturating stall/access counters.
module mem_stage_dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] EX_MEM_ALU_out,
  input  logic [17:0] EX_MEM_MEM_signals,
  output logic [15:0] MEM_rdata,
  output logic        MEM_rvalid,
  output logic        MEM_stall,
  output logic        MEM_busy
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_access_cnt
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [15:0]     rdata_q;
  logic            rvalid_q;
  logic [15:0]     mem [DEPTH_WORDS];

  logic            req_en;
  logic            req_we;
  logic [AW-1:0]   req_idx;
  logic [15:0]     req_wdata;
  logic            fire;
  logic [AW-1:0]   acc_idx;
  logic [15:0]     acc_wdata;
  logic            acc_we;
  logic            unused_addr;

  assign req_en      = EX_MEM_MEM_signals[1];
  assign req_we      = EX_MEM_MEM_signals[0];
  assign req_wdata   = EX_MEM_MEM_signals[17:2];
  assign req_idx     = EX_MEM_ALU_out[AW:1];
  assign unused_addr = ^EX_MEM_ALU_out;

  // The accept cycle is stall cycle 0, so ACCESS lasts LATENCY-1 cycles and
  // a LATENCY of 1 completes straight from IDLE using the live request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    MEM_stall = 1'b0;
    fire      = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    case (state_q)
      IDLE: begin
        if (req_en) begin
          MEM_stall = 1'b1;
          idx_d     = req_idx;
          wdata_d   = req_wdata;
          we_d      = req_we;
          if (LATENCY == 1) begin
            fire      = 1'b1;
            acc_idx   = req_idx;
            acc_wdata = req_wdata;
            acc_we    = req_we;
            cnt_d     = 4'd0;
            state_d   = DONE;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        MEM_stall = 1'b1;
        if (cnt_q <= 4'd1) begin
          fire    = 1'b1;
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 16'h0000;
      we_q     <= 1'b0;
      rdata_q  <= 16'h0000;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rvalid_q <= fire && !acc_we;
      if (fire && !acc_we) rdata_q <= mem[acc_idx];
    end
  end

  // Array contents survive reset; a reset mid-access clears fire before any edge.
  always_ff @(posedge clk) begin
    if (fire && acc_we) mem[acc_idx] <= acc_wdata;
  end

  assign MEM_rdata  = rdata_q;
  assign MEM_rvalid = rvalid_q;
  assign MEM_busy   = (state_q != IDLE);

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] stall_cnt_q, access_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 16'h0000;
      access_cnt_q <= 16'h0000;
    end else begin
      if (MEM_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (state_q == IDLE && req_en && access_cnt_q != 16'hFFFF)
        access_cnt_q <= access_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_access_cnt = access_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// tb/tb_mem_stage_dmem_ctrl.sv - scoreboard bench for mem_stage_dmem_ctrl
module tb_mem_stage_dmem_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu = 16'h0000;
  logic [17:0] sig = 18'h0;
  logic [15:0] rdata;
  logic        rvalid, stall, busy;
`ifdef DMEM_PERF_CNT_EN
  logic [15:0] perf_stall, perf_access;
`endif

  mem_stage_dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .EX_MEM_ALU_out(alu),
    .EX_MEM_MEM_signals(sig),
    .MEM_rdata(rdata),
    .MEM_rvalid(rvalid),
    .MEM_stall(stall),
    .MEM_busy(busy)
`ifdef DMEM_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall),
    .perf_access_cnt(perf_access)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_reads = 0;
  int cyc = 0;
  int n_acc = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every read-completion pulse must match the oldest expected read.
  always @(negedge clk) begin
    #2;
    if (rst_n && rvalid) begin
      n_reads++;
      if (exp_q.size() == 0) chk("rvalid_unexpected", {31'd0, rvalid}, 32'd0);
      else chk("rdata", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic do_access(input logic [15:0] addr, input logic [15:0] data,
                           input logic we, output int acc_cyc);
    int sc;
    @(negedge clk);
    alu = addr;
    sig = {data, 1'b1, we};
    if (!we) exp_q.push_back(data);
    #1;
    acc_cyc = cyc;
    sc = 0;
    while (stall && sc < 40) begin
      sc++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", sc, LAT);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    sig = {data, 1'b0, we};
    n_acc++;
    @(posedge clk);
  endtask

  initial begin
    int a0, a1, t0;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, t0, t1;
    repeat (3) @(negedge clk);
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(16'h0010, 16'hBEEF, 1'b1, a0);
    #1;
    chk("rdata_after_write", {16'd0, rdata}, 32'h0000);

    do_access(16'h0010, 16'hBEEF, 1'b0, a0);
    do_access(16'h0011, 16'hBEEF, 1'b0, a0);

    do_access(16'h0000, 16'h1234, 1'b1, a0);
    #1;
    chk("rdata_held_over_write", {16'd0, rdata}, 32'hBEEF);
    do_access(16'h0800, 16'h1234, 1'b0, a0);

    // No-op: MemWrite without MemEnable
    @(negedge clk);
    alu = 16'h0010;
    sig = {16'h9999, 1'b0, 1'b1};
    #1;
    chk("noop_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("noop_busy", {31'd0, busy}, 32'd0);
    sig = 18'h0;
    do_access(16'h0010, 16'hBEEF, 1'b0, a0);

    // Back-to-back write then read
    do_access(16'h0020, 16'hAAAA, 1'b1, a0);
    do_access(16'h0020, 16'hAAAA, 1'b0, a1);
    #1;
    t1 = cyc;
    chk("b2b_second_accept", a1 - a0, 5);
    chk("b2b_total_cycles", t1 - a0, 10);

    // Reset in ACCESS cycle 2 of a write
    do_access(16'h0030, 16'h0F0F, 1'b1, a0);
    @(negedge clk);
    alu = 16'h0030;
    sig = {16'h5555, 1'b1, 1'b1};
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    sig = 18'h0;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_rdata", {16'd0, rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_acc = 0;
    do_access(16'h0030, 16'h0F0F, 1'b0, a0);
    do_access(16'h0010, 16'hBEEF, 1'b0, a0);
    do_access(16'h0000, 16'h1234, 1'b0, a0);

    repeat (4) @(negedge clk);
    #3;
`ifdef DMEM_PERF_CNT_EN
    chk("perf_access", {16'd0, perf_access}, n_acc);
    chk("perf_stall", {16'd0, perf_stall}, n_acc * LAT);
`endif
    chk("reads_seen", n_reads, 8);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
